// File: rtl/c5_parallel_fault_engine.sv
// c5_parallel_fault_engine: bit-parallel single-stuck-at fault sweep over f = (a^b | c) | (d & (a^b)), W patterns per word.
// Ports:
//     i_clk, i_rst_n            rising-edge clock, synchronous active-low reset
//     i_in_valid / o_in_ready   pattern block handshake carrying i_pat_a..d, i_lane_en, i_drop_en
//     i_clr_det                 clears the sticky detection record, honoured only while idle
//     o_out_valid / i_out_ready result handshake carrying o_out_fid, o_out_diff, o_out_det
//     o_done                    one-cycle pulse once the sweep has fully drained
//     o_detected, o_det_count   sticky per-fault detection flags and their popcount
module c5_parallel_fault_engine #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_pat_a,
    input  logic [W-1:0] i_pat_b,
    input  logic [W-1:0] i_pat_c,
    input  logic [W-1:0] i_pat_d,
    input  logic [W-1:0] i_lane_en,
    input  logic         i_drop_en,
    input  logic         i_clr_det,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [3:0]   o_out_fid,
    output logic [W-1:0] o_out_diff,
    output logic         o_out_det,
    output logic         o_done,
    output logic [15:0]  o_detected,
    output logic [4:0]   o_det_count
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_a, r_b, r_c, r_d, r_lane;
    logic         r_drop;
    logic [3:0]   r_fid;
    logic [15:0]  r_detected, w_detected_nxt;
    logic [4:0]   r_det_count, w_det_count_nxt;
    logic         r_out_valid, r_out_det;
    logic [3:0]   r_out_fid;
    logic [W-1:0] r_out_diff;
    logic         w_room, w_accept, w_adv, w_load, w_hit;
    logic [2:0]   w_site;
    logic [W-1:0] w_force, w_fa, w_fb, w_fc, w_fd, w_w1, w_w2, w_w3, w_f, w_gold, w_diff;
    // Fault id = {site, stuck value}; the forced net replaces only itself, downstream is recomputed.
    assign w_site  = r_fid[3:1];
    assign w_force = {W{r_fid[0]}};
    assign w_fa    = (w_site == 3'd0) ? w_force : r_a;
    assign w_fb    = (w_site == 3'd1) ? w_force : r_b;
    assign w_fc    = (w_site == 3'd2) ? w_force : r_c;
    assign w_fd    = (w_site == 3'd3) ? w_force : r_d;
    assign w_w1    = (w_site == 3'd4) ? w_force : w_fa ^ w_fb;
    assign w_w2    = (w_site == 3'd5) ? w_force : w_w1 | w_fc;
    assign w_w3    = (w_site == 3'd6) ? w_force : w_fd & w_w1;
    assign w_f     = (w_site == 3'd7) ? w_force : w_w2 | w_w3;
    assign w_gold  = ((r_a ^ r_b) | r_c) | (r_d & (r_a ^ r_b));
    assign w_diff  = (w_gold ^ w_f) & r_lane;
    // Room in the output register gates both loads and skips so fid freezes during a stall.
    assign w_room  = !r_out_valid || i_out_ready;
    assign w_hit   = r_drop && r_detected[r_fid];
    assign w_load  = w_adv && !w_hit;
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept    = i_in_valid;
                w_state_nxt = i_in_valid ? SWEEP : IDLE;
            end
            SWEEP: begin
                w_adv       = w_room;
                w_state_nxt = (w_room && r_fid == 4'd15) ? DRAIN : SWEEP;
            end
            // Hold here until the last emitted result is consumed so done never overlaps out_valid.
            DRAIN:   w_state_nxt = w_room ? DONE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_comb begin
        w_detected_nxt = r_detected;
        if (r_state == IDLE && i_clr_det)
            w_detected_nxt = '0;
        else if (w_load && |w_diff)
            w_detected_nxt[r_fid] = 1'b1;
        w_det_count_nxt = '0;
        for (int k = 0; k < 16; k++)
            w_det_count_nxt = w_det_count_nxt + 5'(w_detected_nxt[k]);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_lane      <= '0;
            r_drop      <= 1'b0;
            r_fid       <= '0;
            r_out_valid <= 1'b0;
            r_out_fid   <= '0;
            r_out_diff  <= '0;
            r_out_det   <= 1'b0;
            r_detected  <= '0;
            r_det_count <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= i_pat_a;
                r_b    <= i_pat_b;
                r_c    <= i_pat_c;
                r_d    <= i_pat_d;
                r_lane <= i_lane_en;
                r_drop <= i_drop_en;
                r_fid  <= '0;
            end else if (w_adv) begin
                r_fid <= r_fid + 4'd1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_fid   <= r_fid;
                r_out_diff  <= w_diff;
                r_out_det   <= |w_diff;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_detected  <= w_detected_nxt;
            r_det_count <= w_det_count_nxt;
        end
    end
    assign o_in_ready  = (r_state == IDLE) && i_rst_n;
    assign o_done      = (r_state == DONE);
    assign o_out_valid = r_out_valid;
    assign o_out_fid   = r_out_fid;
    assign o_out_diff  = r_out_diff;
    assign o_out_det   = r_out_det;
    assign o_detected  = r_detected;
    assign o_det_count = r_det_count;
endmodule

// File: tb/tb_c5_parallel_fault_engine.sv
// tb_c5_parallel_fault_engine: directed-vector bench for the c5 fault sweep engine at W=4.
module tb_c5_parallel_fault_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] pat_a = '0, pat_b = '0, pat_c = '0, pat_d = '0, lane_en = '0;
    logic       drop_en = 1'b0;
    logic       clr_det = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_fid;
    logic [3:0] out_diff;
    logic       out_det;
    logic       done;
    logic [15:0] detected;
    logic [4:0] det_count;

    c5_parallel_fault_engine #(.W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_pat_a(pat_a), .i_pat_b(pat_b), .i_pat_c(pat_c), .i_pat_d(pat_d),
        .i_lane_en(lane_en), .i_drop_en(drop_en), .i_clr_det(clr_det),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_fid(out_fid),
        .o_out_diff(out_diff), .o_out_det(out_det), .o_done(done),
        .o_detected(detected), .o_det_count(det_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Hand-computed diffs for a=0101 b=0011 c=0000 d=1111 (golden f=0110), indexed by fault id.
    logic [3:0] exp_full [16] = '{4'b0101, 4'b1010, 4'b0011, 4'b1100, 4'b0000, 4'b1001, 4'b0000, 4'b0000,
                                  4'b0110, 4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b1001, 4'b0110, 4'b1001};

    logic [3:0] got_fid [$];
    logic [3:0] got_diff [$];
    logic       got_det [$];
    int         done_cyc;
    logic       done_ov;
    logic [15:0] done_detected;
    logic [4:0] done_count;
    logic       hold_bad;
    logic       send_timeout;

    // Presents one block and waits for the accepting edge; leaves time at #1 after that edge.
    task automatic send(input logic [3:0] a, b, c, d, lane, input logic drop);
        pat_a = a; pat_b = b; pat_c = c; pat_d = d; lane_en = lane; drop_en = drop;
        in_valid = 1'b1;
        send_timeout = 1'b0;
        for (int k = 0; k < 5 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) send_timeout = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pat_a = 4'hF; pat_b = 4'hF; pat_c = 4'hF; pat_d = 4'hF; lane_en = 4'h0;
    endtask

    // Collects the result stream after an accept; cycles are counted from the accepting edge.
    task automatic observe(input int stall_fid, input int stall_len, input int clr_cyc, input logic noise);
        int sc;
        logic [3:0] h_fid;
        logic [3:0] h_diff;
        sc = 0; h_fid = '0; h_diff = '0;
        got_fid.delete(); got_diff.delete(); got_det.delete();
        done_cyc = -1; done_ov = 1'b1; hold_bad = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            clr_det = (cyc == clr_cyc);
            if (noise) begin
                in_valid = 1'b1;
                pat_a = 4'hA; pat_b = 4'h5; pat_c = 4'hC; pat_d = 4'h0; lane_en = 4'hF;
            end
            if (done) begin
                done_cyc = cyc; done_ov = out_valid; done_detected = detected; done_count = det_count;
                break;
            end
            if (out_valid && int'(out_fid) == stall_fid && sc < stall_len) begin
                if (sc == 0) begin
                    h_fid = out_fid; h_diff = out_diff;
                end else if (out_fid !== h_fid || out_diff !== h_diff) begin
                    hold_bad = 1'b1;
                end
                out_ready = 1'b0;
                sc++;
            end else begin
                if (sc > 0 && sc == stall_len && out_valid && int'(out_fid) == stall_fid &&
                    out_diff !== h_diff) hold_bad = 1'b1;
                out_ready = 1'b1;
                if (out_valid) begin
                    got_fid.push_back(out_fid);
                    got_diff.push_back(out_diff);
                    got_det.push_back(out_det);
                end
            end
        end
        clr_det = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({in_ready, out_valid, out_fid, out_diff, out_det, done} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b fid=%h diff=%h det=%b done=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, out_fid, out_diff, out_det, done);
        end
        vectors++;
        if (detected !== 16'h0 || det_count !== 5'd0) begin
            miscompares++; $display("FAIL reset_detected: got %h/%0d want 0000/0", detected, det_count);
        end
    endtask

    task automatic test_full_sweep;
        send(4'b0101, 4'b0011, 4'b0000, 4'b1111, 4'b1111, 1'b0);
        observe(-1, 0, 0, 1'b1);
        vectors++;
        if (got_fid.size() != 16) begin
            miscompares++; $display("FAIL full_count: got %0d results want 16", got_fid.size());
        end
        for (int i = 0; i < got_fid.size() && i < 16; i++) begin
            vectors++;
            if (got_fid[i] !== 4'(i) || got_diff[i] !== exp_full[i] || got_det[i] !== |exp_full[i]) begin
                miscompares++;
                $display("FAIL full_result[%0d]: got fid=%0d diff=%b det=%b want fid=%0d diff=%b det=%b",
                         i, got_fid[i], got_diff[i], got_det[i], i, exp_full[i], |exp_full[i]);
            end
        end
        vectors++;
        if (done_cyc != 17 || done_ov !== 1'b0) begin
            miscompares++; $display("FAIL full_done: got cycle %0d ov=%b want 17 0", done_cyc, done_ov);
        end
        vectors++;
        if (done_detected !== 16'hEB2F || done_count !== 5'd11) begin
            miscompares++; $display("FAIL full_detected: got %h/%0d want eb2f/11", done_detected, done_count);
        end
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++; $display("FAIL full_after_done: got rdy=%b done=%b want 1 0", in_ready, done);
        end
    endtask

    task automatic test_drop;
        logic [3:0] exp_fids [5] = '{4'd4, 4'd6, 4'd7, 4'd10, 4'd12};
        send(4'b0101, 4'b0011, 4'b0000, 4'b1111, 4'b1111, 1'b1);
        observe(-1, 0, 0, 1'b0);
        vectors++;
        if (got_fid.size() != 5) begin
            miscompares++; $display("FAIL drop_count: got %0d results want 5", got_fid.size());
        end
        for (int i = 0; i < got_fid.size() && i < 5; i++) begin
            vectors++;
            if (got_fid[i] !== exp_fids[i] || got_diff[i] !== 4'b0000) begin
                miscompares++;
                $display("FAIL drop_result[%0d]: got fid=%0d diff=%b want fid=%0d diff=0000",
                         i, got_fid[i], got_diff[i], exp_fids[i]);
            end
        end
        vectors++;
        if (done_cyc != 17 || done_detected !== 16'hEB2F || done_count !== 5'd11) begin
            miscompares++;
            $display("FAIL drop_done: got cycle %0d det=%h/%0d want 17 eb2f/11", done_cyc, done_detected, done_count);
        end
    endtask

    task automatic test_clr_lane;
        @(posedge clk); #1;
        clr_det = 1'b1;
        @(posedge clk); #1;
        clr_det = 1'b0;
        vectors++;
        if (detected !== 16'h0 || det_count !== 5'd0) begin
            miscompares++; $display("FAIL clr_idle: got %h/%0d want 0000/0", detected, det_count);
        end
        send(4'b0101, 4'b0011, 4'b0000, 4'b1111, 4'b0001, 1'b0);
        observe(-1, 0, 0, 1'b0);
        vectors++;
        if (got_fid.size() != 16) begin
            miscompares++; $display("FAIL lane_count: got %0d results want 16", got_fid.size());
        end
        for (int i = 0; i < got_fid.size() && i < 16; i++) begin
            vectors++;
            if (got_diff[i] !== (exp_full[i] & 4'b0001)) begin
                miscompares++;
                $display("FAIL lane_result[%0d]: got diff=%b want %b", i, got_diff[i], exp_full[i] & 4'b0001);
            end
        end
        // Lane 0 differs for fids 0,2,5,9,11,13,15.
        vectors++;
        if (done_detected !== 16'hAA25 || done_count !== 5'd7) begin
            miscompares++; $display("FAIL lane_detected: got %h/%0d want aa25/7", done_detected, done_count);
        end
    endtask

    task automatic test_stall;
        send(4'b0101, 4'b0011, 4'b0000, 4'b1111, 4'b1111, 1'b0);
        observe(2, 3, 0, 1'b0);
        vectors++;
        if (hold_bad !== 1'b0) begin
            miscompares++; $display("FAIL stall_hold: got changed outputs during stall want held");
        end
        vectors++;
        if (got_fid.size() != 16 || got_fid[2] !== 4'd2 || got_diff[2] !== 4'b0011 || got_fid[3] !== 4'd3) begin
            miscompares++;
            $display("FAIL stall_results: got %0d results fid2=%0d diff=%b want 16 results fid2 diff 0011",
                     got_fid.size(), got_fid[2], got_diff[2]);
        end
        vectors++;
        if (done_cyc != 20 || done_detected !== 16'hEB2F || done_count !== 5'd11) begin
            miscompares++;
            $display("FAIL stall_done: got cycle %0d det=%h/%0d want 20 eb2f/11", done_cyc, done_detected, done_count);
        end
    endtask

    task automatic test_clr_mid_sweep;
        send(4'b0101, 4'b0011, 4'b0000, 4'b1111, 4'b1111, 1'b0);
        observe(-1, 0, 6, 1'b0);
        vectors++;
        if (done_cyc != 17 || done_detected !== 16'hEB2F || done_count !== 5'd11) begin
            miscompares++;
            $display("FAIL clr_mid: got cycle %0d det=%h/%0d want 17 eb2f/11", done_cyc, done_detected, done_count);
        end
    endtask

    task automatic test_reset_mid_sweep;
        logic seen;
        seen = 1'b0;
        send(4'b0101, 4'b0011, 4'b0000, 4'b1111, 4'b1111, 1'b0);
        for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
            if (out_valid && out_fid == 4'd7) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL rstmid_reach_fid7: got no fid 7 want fid 7 within 30 cycles");
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_ready_low: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || detected !== 16'h0 || det_count !== 5'd0) begin
            miscompares++;
            $display("FAIL rstmid_state: got rdy=%b ov=%b det=%h/%0d want 1 0 0000/0",
                     in_ready, out_valid, detected, det_count);
        end
        send(4'b0101, 4'b0011, 4'b0000, 4'b1111, 4'b1111, 1'b0);
        observe(-1, 0, 0, 1'b0);
        vectors++;
        if (got_fid.size() != 16 || got_fid[0] !== 4'd0 || got_diff[0] !== 4'b0101) begin
            miscompares++;
            $display("FAIL rstmid_restart: got %0d results first fid=%0d diff=%b want 16 fid0 0101",
                     got_fid.size(), got_fid[0], got_diff[0]);
        end
        vectors++;
        if (done_cyc != 17 || done_detected !== 16'hEB2F || done_count !== 5'd11) begin
            miscompares++;
            $display("FAIL rstmid_done: got cycle %0d det=%h/%0d want 17 eb2f/11", done_cyc, done_detected, done_count);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_drop();
        test_clr_lane();
        test_stall();
        test_clr_mid_sweep();
        test_reset_mid_sweep();
        vectors++;
        if (send_timeout !== 1'b0) begin
            miscompares++; $display("FAIL send_ready: got in_ready never asserted want ready");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
